// File: rtl/clb_cfg_pkg.sv
// Shared constants and types for the clb44 serial configuration loader.
package clb_cfg_pkg;

  // Configuration word, preamble and power-up defaults
  localparam int              CFG_W   = 37;
  localparam int              PRE_W   = 8;
  localparam logic [PRE_W-1:0] PRE    = 8'hA5;
  localparam logic [CFG_W-1:0] CFG_RST = 37'h0380A80116;

  // Field layout of the clb44 configuration word (LSB offset, width)
  localparam int MEM_LSB        = 0;   localparam int MEM_W        = 16;
  localparam int COMBOPT_LSB    = 16;  localparam int COMBOPT_W    = 2;
  localparam int MUX2SEL_LSB    = 18;  localparam int MUX2SEL_W    = 2;
  localparam int MUX3SEL_LSB    = 20;  localparam int MUX3SEL_W    = 2;
  localparam int MUX4SEL_LSB    = 22;  localparam int MUX4SEL_W    = 2;
  localparam int MUX5SEL_LSB    = 24;  localparam int MUX5SEL_W    = 2;
  localparam int MUX6SEL_LSB    = 26;  localparam int MUX6SEL_W    = 2;
  localparam int O2M_0_LSB      = 28;  localparam int O2M_0_W      = 3;
  localparam int O2M_1_LSB      = 31;  localparam int O2M_1_W      = 3;
  localparam int DQMUX1_LSB     = 34;  localparam int DQMUX1_W     = 1;
  localparam int DQMUX2_LSB     = 35;  localparam int DQMUX2_W     = 1;
  localparam int FLOPORLATCH_LSB = 36; localparam int FLOPORLATCH_W = 1;

  // Loader states: hunting the preamble, shifting payload, checking parity
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOAD = 2'd1,
    PAR  = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/clb_cfg_loader_preamble_det.sv
// Sliding preamble detector: shifts accepted bits into a window and flags the
// cycle on which the window (including the incoming bit) equals the pattern.
module cfg_preamble_det #(
  parameter int               PRE_W = 8,
  parameter logic [PRE_W-1:0] PRE   = 8'hA5
) (
  input  logic K,
  input  logic RST,
  input  logic DIN,
  input  logic DVALID,
  input  logic CLR,
  output logic HIT
);

  logic [PRE_W-1:0] sr_q;
  logic [PRE_W-1:0] sr_d;

  // Window after this cycle's bit, used both for the compare and the update
  always_comb begin
    sr_d = {sr_q[PRE_W-2:0], DIN};
  end

  // Window register; clear holds it empty while a frame is in flight
  always_ff @(posedge K) begin
    if (RST || CLR) begin
      sr_q <= '0;
    end else if (DVALID) begin
      sr_q <= sr_d;
    end
  end

  assign HIT = DVALID && !CLR && (sr_d == PRE);

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for clb44: hunts the preamble, shifts in one
// configuration frame, checks even parity and commits only clean frames.
// Handshake: DIN is consumed on every cycle DVALID is high; when DVALID is low
// nothing changes, so gaps of any length are allowed. There is no ready.
module clb_cfg_loader #(
  parameter int               CFG_W   = clb_cfg_pkg::CFG_W,
  parameter int               PRE_W   = clb_cfg_pkg::PRE_W,
  parameter logic [PRE_W-1:0] PRE     = clb_cfg_pkg::PRE,
  parameter logic [CFG_W-1:0] CFG_RST = clb_cfg_pkg::CFG_RST
) (
  input  logic                    K,
  input  logic                    RST,
  input  logic                    DIN,
  input  logic                    DVALID,
  output logic [CFG_W-1:0]        CFG,
  output logic                    CFG_VALID,
  output logic                    ERR,
  output logic                    BUSY,
  output clb_cfg_pkg::cfg_state_e STATE_DBG
);

  import clb_cfg_pkg::*;

  localparam int         CNT_W = 6;
  localparam [CNT_W-1:0] LAST  = CNT_W'(CFG_W - 1);

  cfg_state_e       state_q, state_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             pre_hit;
  logic             det_clr;

  // The detector only watches the stream while hunting
  assign det_clr = (state_q != HUNT);

  cfg_preamble_det #(
    .PRE_W (PRE_W),
    .PRE   (PRE)
  ) u_det (
    .K      (K),
    .RST    (RST),
    .DIN    (DIN),
    .DVALID (DVALID),
    .CLR    (det_clr),
    .HIT    (pre_hit)
  );

  // Next-state logic for the frame FSM and its registered outputs
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    cfg_d       = cfg_q;
    cfg_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      HUNT: begin
        if (pre_hit) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          par_d    = 1'b0;
        end
      end
      LOAD: begin
        if (DVALID) begin
          shadow_d = {shadow_q[CFG_W-2:0], DIN};
          par_d    = par_q ^ DIN;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = PAR;
          end
        end
      end
      PAR: begin
        if (DVALID) begin
          if ((par_q ^ DIN) == 1'b0) begin
            cfg_d       = shadow_q;
            cfg_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
    busy_d = (state_d != HUNT);
  end

  // State and output registers; reset wins over any DVALID in the same cycle
  always_ff @(posedge K) begin
    if (RST) begin
      state_q     <= HUNT;
      shadow_q    <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      cfg_q       <= CFG_RST;
      cfg_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign CFG       = cfg_q;
  assign CFG_VALID = cfg_valid_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader: directed frame table, hand-written
// corner sequences and randomized streams against a bit-stream reference model.
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int W = CFG_W;

  // ---------------- clock / reset / DUT ----------------
  logic         k = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         dvalid = 1'b0;
  logic [W-1:0] cfg;
  logic         cfg_valid;
  logic         err;
  logic         busy;
  cfg_state_e   state_dbg;

  always #5 k = ~k;

  clb_cfg_loader dut (
    .K         (k),
    .RST       (rst),
    .DIN       (din),
    .DVALID    (dvalid),
    .CFG       (cfg),
    .CFG_VALID (cfg_valid),
    .ERR       (err),
    .BUSY      (busy),
    .STATE_DBG (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int busy_cnt, valid_cnt, err_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the last PRE_W stream bits while outside a frame; once they spell
  // the preamble, the next W+1 bits form payload plus parity.
  logic         m_hist[$];
  logic         m_frame[$];
  bit           m_in;
  logic [W-1:0] m_cfg;
  logic         m_valid, m_err, m_busy;

  function automatic void model_reset();
    m_hist.delete();
    m_frame.delete();
    m_in    = 1'b0;
    m_cfg   = CFG_RST;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_busy  = 1'b0;
  endfunction

  function automatic logic [PRE_W-1:0] hist_val();
    logic [PRE_W-1:0] v = '0;
    foreach (m_hist[i]) v = {v[PRE_W-2:0], m_hist[i]};
    return v;
  endfunction

  function automatic void model_cycle(input logic b, input logic dv);
    logic [W-1:0] payload;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!dv) return;
    if (!m_in) begin
      m_hist.push_back(b);
      if (m_hist.size() > PRE_W) void'(m_hist.pop_front());
      if (m_hist.size() == PRE_W && hist_val() == PRE) begin
        m_in = 1'b1;
        m_frame.delete();
      end
    end else begin
      m_frame.push_back(b);
      if (m_frame.size() == W + 1) begin
        payload = '0;
        for (int i = 0; i < W; i++) payload = {payload[W-2:0], m_frame[i]};
        if (($countones(payload) + int'(b)) % 2 == 0) begin
          m_cfg   = payload;
          m_valid = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_in = 1'b0;
        m_hist.delete();
      end
    end
    m_busy = m_in;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic b, input logic dv);
    @(negedge k);
    din    = b;
    dvalid = dv;
    @(posedge k);
    #1;
    model_cycle(b, dv);
    chk("cfg", 64'(cfg), 64'(m_cfg));
    chk("cfg_valid", 64'(cfg_valid), 64'(m_valid));
    chk("err", 64'(err), 64'(m_err));
    chk("busy", 64'(busy), 64'(m_busy));
    if (busy) busy_cnt++;
    if (cfg_valid) valid_cnt++;
    if (err) err_cnt++;
  endtask

  task automatic send_bit(input logic b, input int stall_max);
    int gap = $urandom_range(0, stall_max);
    repeat (gap) step(1'($urandom_range(0, 1)), 1'b0);
    step(b, 1'b1);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int stall_max);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], stall_max);
  endtask

  task automatic send_frame(input logic [W-1:0] payload, input logic par, input int stall_max);
    send_bits(64'(PRE), PRE_W, stall_max);
    send_bits(64'(payload), W, stall_max);
    send_bit(par, stall_max);
  endtask

  task automatic do_reset();
    @(negedge k);
    rst    = 1'b1;
    dvalid = 1'b1;
    din    = 1'b1;
    repeat (2) @(posedge k);
    #1;
    model_reset();
    chk("rst_cfg", 64'(cfg), 64'(CFG_RST));
    chk("rst_cfg_valid", 64'(cfg_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(HUNT));
    @(negedge k);
    rst    = 1'b0;
    dvalid = 1'b0;
    din    = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [W-1:0] payload;
    logic         par;
    int           stall_max;
    logic [W-1:0] exp_cfg;
    int           exp_valid;
    int           exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [11:0]  slide;
    logic [W-1:0] p;
    logic         pb;

    vecs[0] = '{37'h0000000FFFF, 1'b0, 0, 37'h0000000FFFF, 1, 0};  // good frame
    vecs[1] = '{37'h0000000FFFF, 1'b1, 0, 37'h0000000FFFF, 0, 1};  // bad parity, keep prior
    vecs[2] = '{37'h1000000001,  1'b0, 5, 37'h1000000001,  1, 0};  // stalls, MSB and LSB set
    vecs[3] = '{37'h00A5A5A5A5,  1'b0, 0, 37'h00A5A5A5A5,  1, 0};  // preamble-like payload
    vecs[4] = '{37'h1FFFFFFFFF,  1'b1, 3, 37'h1FFFFFFFFF,  1, 0};  // all ones, odd count
    vecs[5] = '{37'h0000000001,  1'b0, 0, 37'h1FFFFFFFFF,  0, 1};  // bad parity, keep prior

    model_reset();
    do_reset();

    foreach (vecs[i]) begin
      busy_cnt  = 0;
      valid_cnt = 0;
      err_cnt   = 0;
      send_frame(vecs[i].payload, vecs[i].par, vecs[i].stall_max);
      chk($sformatf("vec%0d_cfg", i), 64'(cfg), 64'(vecs[i].exp_cfg));
      chk($sformatf("vec%0d_valid_pulses", i), 64'(valid_cnt), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_err_pulses", i), 64'(err_cnt), 64'(vecs[i].exp_err));
      if (vecs[i].stall_max == 0) chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_cnt), 64'd38);
      step(1'b0, 1'b0);
    end

    // Sliding preamble: 1010_1010_0101 must hit on the 12th bit only
    slide = 12'hAA5;
    for (int i = 11; i >= 0; i--) begin
      send_bit(slide[i], 0);
      if (i == 1) chk("slide_no_early_hit", 64'(busy), 64'd0);
      if (i == 0) chk("slide_hit", 64'(busy), 64'd1);
    end
    send_bits(64'(37'h0123456789), W, 0);
    send_bit(^37'h0123456789, 0);
    chk("slide_cfg", 64'(cfg), 64'(37'h0123456789));

    // Reset mid-frame after a committed frame
    send_frame(37'h0000000FFFF, 1'b0, 0);
    chk("pre_rst_cfg", 64'(cfg), 64'(37'h0000000FFFF));
    send_bits(64'(PRE), PRE_W, 0);
    send_bits(64'hABCDE, 20, 0);
    chk("midframe_busy", 64'(busy), 64'd1);
    do_reset();
    valid_cnt = 0;
    send_frame(37'h0A5A5A5A5A, ^37'h0A5A5A5A5A, 2);
    chk("post_rst_cfg", 64'(cfg), 64'(37'h0A5A5A5A5A));
    chk("post_rst_valid_pulses", 64'(valid_cnt), 64'd1);

    // Randomized streams: noise, then frames with random payload and parity
    for (int f = 0; f < 16; f++) begin
      int noise = $urandom_range(0, 10);
      for (int j = 0; j < noise; j++) send_bit(1'($urandom_range(0, 1)), 2);
      p  = W'({$urandom(), $urandom()});
      pb = ($urandom_range(0, 3) == 0) ? ~(^p) : ^p;
      send_frame(p, pb, $urandom_range(0, 3));
    end
    step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
